// File: rtl/arith_sched_pkg.sv
// Shared types for the arithmetic scheduler: datapath opcode, scheduler
// state encoding and default datapath width.
package arith_sched_pkg;

  localparam int ARITH_W = 8;
  localparam int OPER_W  = 5;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_MUL = 5'd2,
    OP_DIV = 5'd3,
    OP_AND = 5'd4,
    OP_OR  = 5'd5,
    OP_XOR = 5'd6,
    OP_SHL = 5'd7,
    OP_SHR = 5'd8
  } oper_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/arith_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above
// 'last', wrapping around; the caller owns the 'last' register.
module arith_sched_rr_arbiter
  import arith_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest valid wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_idx    = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(last) + k) % N);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        grant_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/arith_sched.sv
// Round-robin scheduler sharing one arithmetic datapath between NREQ
// requesters: accept, launch, wait for done or timeout, respond.
module arith_sched
  import arith_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = ARITH_W,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ*OPER_W-1:0]   req_sel,
  output logic [W-1:0]             arith_a,
  output logic [W-1:0]             arith_b,
  output oper_t                    arith_sel,
  output logic                     arith_start,
  input  logic                     arith_done,
  input  logic [W-1:0]             arith_hi,
  input  logic [W-1:0]             arith_lo,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [W-1:0]             resp_hi,
  output logic [W-1:0]             resp_lo,
  output logic                     resp_err,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NREQ - 1);

  sched_state_t  r_state, w_state_nxt;
  logic [IW-1:0] r_last_grant, r_cur_id, w_grant_id;
  logic [NREQ-1:0] w_grant;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic          w_accept, w_timeout;
  logic          r_busy, r_start, r_resp_valid, r_resp_err;
  logic [W-1:0]  r_arith_a, r_arith_b, r_resp_hi, r_resp_lo;
  oper_t         r_arith_sel;

  arith_sched_rr_arbiter #(.N(NREQ)) u_arb (
    .req      (req_valid),
    .last     (r_last_grant),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  assign w_accept  = (r_state == IDLE) && (|req_valid);
  assign w_cnt_inc = r_cnt + CW'(1);
  // Compare the post-increment value so the abort lands TIMEOUT cycles after start.
  assign w_timeout = (w_cnt_inc == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          req_ready   = w_grant;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (arith_done || w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ID_LAST;
      r_cur_id     <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_start      <= (w_state_nxt == ISSUE);
      r_resp_valid <= (w_state_nxt == RESP);
      if (w_accept) r_cur_id <= w_grant_id;
      if (r_state == ISSUE) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= w_cnt_inc;
      if ((r_state == RESP) && resp_ready) r_last_grant <= r_cur_id;
    end
  end

  // Operand capture on accept; result capture in WAIT, where done beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arith_a   <= '0;
      r_arith_b   <= '0;
      r_arith_sel <= OP_ADD;
      r_resp_hi   <= '0;
      r_resp_lo   <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_arith_a   <= req_a[int'(w_grant_id)*W +: W];
        r_arith_b   <= req_b[int'(w_grant_id)*W +: W];
        r_arith_sel <= oper_t'(req_sel[int'(w_grant_id)*OPER_W +: OPER_W]);
      end
      if (r_state == WAIT) begin
        if (arith_done) begin
          r_resp_hi  <= arith_hi;
          r_resp_lo  <= arith_lo;
          r_resp_err <= 1'b0;
        end else if (w_timeout) begin
          r_resp_hi  <= '0;
          r_resp_lo  <= '0;
          r_resp_err <= 1'b1;
        end
      end
    end
  end

  assign arith_a     = r_arith_a;
  assign arith_b     = r_arith_b;
  assign arith_sel   = r_arith_sel;
  assign arith_start = r_start;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_cur_id;
  assign resp_hi     = r_resp_hi;
  assign resp_lo     = r_resp_lo;
  assign resp_err    = r_resp_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_arith_sched.sv
// Randomized scoreboard bench for arith_sched with a behavioural datapath
// and a round-robin reference model.
module tb_arith_sched;
  import arith_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int TO   = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] sel;
    int         dly;   // done delay after start; 0 = never
    bit         spur;  // extra done pulse in the start cycle
  } op_t;

  typedef struct {
    int         id;
    logic [7:0] hi;
    logic [7:0] lo;
    bit         err;
    int         acc_cyc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*5-1:0] req_sel;
  logic [W-1:0]      arith_a, arith_b, arith_hi, arith_lo;
  logic [4:0]        arith_sel;
  logic              arith_start, arith_done;
  logic              resp_valid, resp_ready, resp_err, busy;
  logic [0:0]        resp_id;
  logic [W-1:0]      resp_hi, resp_lo;

  arith_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .arith_a(arith_a), .arith_b(arith_b), .arith_sel(arith_sel),
    .arith_start(arith_start), .arith_done(arith_done),
    .arith_hi(arith_hi), .arith_lo(arith_lo),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] sel);
    case (sel)
      5'd0:    return {8'h00, a} + {8'h00, b};
      5'd1:    return {8'h00, a - b};
      5'd2:    return a * b;
      default: return {a & b, a ^ b};
    endcase
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic op_t mk_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] sel,
                                input int dly, input bit spur);
    op_t o;
    o.a = a; o.b = b; o.sel = sel; o.dly = dly; o.spur = spur;
    return o;
  endfunction

  // Shared model state
  exp_t exp_q[$];
  op_t  pend[NREQ][$];
  int   drv_dly[NREQ];
  bit   drv_spur[NREQ];
  op_t  drv_op[NREQ];
  int   n_acc = 0, n_resp = 0, tb_last = NREQ - 1;
  int   acc_cyc = -100, acc_dly = 0;
  bit   acc_spur = 1'b0;

  // Request side: predict grants and push expected responses.
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g;
    exp_t e;
    bit ok;
    if (!rst_n) begin
      n_acc <= 0;
    end else begin
      er = '0;
      g = -1;
      if (n_acc == n_resp && req_valid != '0) begin
        g = rr_pick(req_valid, tb_last);
        er[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      if (g >= 0) begin
        ok = (drv_dly[g] >= 1) && (drv_dly[g] <= TO - 1);
        e.id = g;
        {e.hi, e.lo} = ok ? ref_op(drv_op[g].a, drv_op[g].b, drv_op[g].sel) : 16'h0000;
        e.err = !ok;
        e.acc_cyc = cyc;
        e.lat = ok ? drv_dly[g] + 2 : TO + 1;
        exp_q.push_back(e);
        n_acc <= n_acc + 1;
        acc_cyc = cyc;
        acc_dly = drv_dly[g];
        acc_spur = drv_spur[g];
      end
    end
  end

  // Behavioural datapath: done after a per-operation delay, optional spurious pulse.
  int dp_start = 0, dp_dly = 0, rel;
  bit dp_pend = 1'b0, dp_spur = 1'b0;
  logic [15:0] dp_res;
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_pend = 1'b0;
      arith_done = 1'b0;
    end else begin
      if (arith_start) begin
        chk("start_latency", 32'(cyc - acc_cyc), 32'(1));
        dp_start = cyc;
        dp_pend = 1'b1;
        dp_res = ref_op(arith_a, arith_b, arith_sel);
        dp_dly = acc_dly;
        dp_spur = acc_spur;
      end
      arith_done = 1'b0;
      arith_hi = 8'($urandom);
      arith_lo = 8'($urandom);
      if (dp_pend) begin
        rel = cyc - dp_start;
        if (dp_spur && rel == 0) arith_done = 1'b1;
        if (dp_dly > 0 && rel == dp_dly) begin
          arith_done = 1'b1;
          {arith_hi, arith_lo} = dp_res;
          dp_pend = 1'b0;
        end
        if (rel > 2 * TO + 20) dp_pend = 1'b0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each consumed response.
  bit resp_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      n_resp <= 0;
      tb_last <= NREQ - 1;
      resp_seen = 1'b0;
    end else if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got id=%0d hi=%0h lo=%0h err=%0b expected no response",
                 resp_id, resp_hi, resp_lo, resp_err);
      end else begin
        e = exp_q[0];
        if (!resp_seen) begin
          chk("resp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          resp_seen = 1'b1;
        end
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_data", 32'({resp_err, resp_hi, resp_lo}), 32'({e.err, e.hi, e.lo}));
        if (resp_ready) begin
          void'(exp_q.pop_front());
          n_resp <= n_resp + 1;
          tb_last <= e.id;
          resp_seen = 1'b0;
        end
      end
    end
  end

  bit resp_rand = 1'b0;

  task automatic load(input int i);
    op_t o;
    if (pend[i].size() > 0) begin
      o = pend[i].pop_front();
      req_a[i*W +: W] = o.a;
      req_b[i*W +: W] = o.b;
      req_sel[i*5 +: 5] = o.sel;
      drv_op[i] = o;
      drv_dly[i] = o.dly;
      drv_spur[i] = o.spur;
      req_valid[i] = 1'b1;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] took;
    @(negedge clk);
    took = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (took[i] || !req_valid[i]) load(i);
    if (resp_rand) resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_until_idle(input string name, input int maxc);
    int n = 0;
    while ((pend[0].size() != 0 || pend[1].size() != 0 || req_valid != '0 ||
            exp_q.size() != 0 || busy) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  function automatic op_t rand_op();
    int r = $urandom_range(0, 9);
    return mk_op(8'($urandom), 8'($urandom), 5'($urandom_range(0, 6)),
                 (r == 9) ? 0 : r, $urandom_range(0, 3) == 0);
  endfunction

  initial begin
    int n;
    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
    resp_ready = 1'b0; arith_hi = '0; arith_lo = '0; arith_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      drv_dly[i] = 0; drv_spur[i] = 1'b0; drv_op[i] = mk_op(8'h00, 8'h00, 5'd0, 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({busy, arith_start, resp_valid, resp_err, req_ready, resp_id}), 32'(0));
    chk("reset_resp", 32'({resp_hi, resp_lo}), 32'(0));
    chk("reset_arith", 32'({arith_a, arith_b, arith_sel}), 32'(0));
    rst_n = 1'b1;
    resp_ready = 1'b1;

    pend[0].push_back(mk_op(8'h0C, 8'h03, 5'(OP_ADD), 1, 1'b0));
    run_until_idle("single_op", 50);

    for (int k = 0; k < 2; k++) begin
      pend[0].push_back(mk_op(8'($urandom), 8'($urandom), 5'(OP_MUL), 1 + k, 1'b0));
      pend[1].push_back(mk_op(8'($urandom), 8'($urandom), 5'(OP_SUB), 2 + k, 1'b0));
    end
    run_until_idle("fairness", 200);

    pend[0].push_back(mk_op(8'h11, 8'h22, 5'(OP_ADD), 0, 1'b0));
    run_until_idle("timeout", 50);

    pend[1].push_back(mk_op(8'hF0, 8'h33, 5'(OP_ADD), TO - 1, 1'b1));
    pend[0].push_back(mk_op(8'h5A, 8'hA5, 5'(OP_XOR), 3, 1'b1));
    pend[0].push_back(mk_op(8'h40, 8'h04, 5'(OP_MUL), TO, 1'b0));
    run_until_idle("spurious_coincident", 200);

    resp_ready = 1'b0;
    pend[0].push_back(mk_op(8'h12, 8'h34, 5'(OP_MUL), 2, 1'b0));
    step();
    step();
    pend[1].push_back(mk_op(8'h09, 8'h07, 5'(OP_SUB), 1, 1'b0));
    n = 0;
    while (!resp_valid && n < 20) begin step(); n++; end
    chk("bp_resp_seen", 32'(resp_valid), 32'(1));
    repeat (5) step();
    resp_ready = 1'b1;
    run_until_idle("backpressure", 100);

    resp_rand = 1'b1;
    for (int k = 0; k < 40; k++) pend[$urandom_range(0, NREQ - 1)].push_back(rand_op());
    run_until_idle("random", 3000);
    resp_rand = 1'b0;
    resp_ready = 1'b1;

    pend[0].push_back(mk_op(8'h01, 8'h02, 5'(OP_ADD), 0, 1'b0));
    n = 0;
    while (!(busy && !arith_start && !resp_valid) && n < 20) begin step(); n++; end
    chk("reached_wait", 32'(busy && !arith_start && !resp_valid), 32'(1));
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({busy, arith_start, resp_valid}), 32'(0));
    pend[0].push_back(mk_op(8'h21, 8'h12, 5'(OP_ADD), 1, 1'b0));
    pend[1].push_back(mk_op(8'h77, 8'h11, 5'(OP_SUB), 1, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) if (!req_valid[i]) load(i);
    run_until_idle("after_reset", 100);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
